// File: rtl/pixel_ctrl_pkg.sv
// Shared types and Gray helpers for the pixel array
// frame sequencer.
package pixel_ctrl_pkg;

  localparam int CNT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ERASE,
    ST_EXPOSE,
    ST_CONVERT,
    ST_RD_SETUP,
    ST_RD_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [CNT_W_DEF-1:0] bin2gray(
    input logic [CNT_W_DEF-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [CNT_W_DEF-1:0] gray2bin(
    input logic [CNT_W_DEF-1:0] g
  );
    logic [CNT_W_DEF-1:0] b;
    b[CNT_W_DEF-1] = g[CNT_W_DEF-1];
    for (int i = CNT_W_DEF - 2; i >= 0; i--)
      b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/pixel_gray_counter.sv
// Conversion counter: binary core, Gray-coded output,
// wrap pulse on the all-ones step.
module pixel_gray_counter
  import pixel_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] gray,
  output logic         wrap
);

  logic [W-1:0] bin;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   bin <= '0;
    else if (clr) bin <= '0;
    else if (en)  bin <= bin + 1'b1;
  end

  assign gray = bin2gray(bin);
  assign wrap = en & (&bin);

endmodule

// File: rtl/pixel_array_ctrl.sv
// Frame sequencer: erase, expose, ramp conversion, then
// four handshaked pixel reads over the shared DATA bus.
module pixel_array_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int C_ERASE      = 5,
  parameter int C_EXPOSE     = 255,
  parameter int C_READ_SETUP = 2,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  output logic             ERASE,
  output logic             EXPOSE,
  output logic             CONVERT,
  output logic             READ1,
  output logic             READ2,
  output logic             READ3,
  output logic             READ4,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_oe,
  input  logic [CNT_W-1:0] data_in,
  output logic [CNT_W-1:0] pix_data,
  output logic [1:0]       pix_idx,
  output logic             pix_valid,
  input  logic             pix_ready
);

  localparam logic [7:0] E_LAST = 8'(C_ERASE - 1);
  localparam logic [7:0] X_LAST = 8'(C_EXPOSE - 1);
  localparam logic [7:0] S_LAST = 8'(C_READ_SETUP - 1);

  state_t     state, state_nxt;
  logic [7:0] tmr;
  logic [1:0] k;
  logic [3:0] rd;
  logic       wrap;

  pixel_gray_counter #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .reset(reset),
    .en   (state == ST_CONVERT),
    .clr  (state == ST_IDLE),
    .gray (cnt_data),
    .wrap (wrap)
  );

  always_comb begin
    state_nxt = state;
    ERASE     = 1'b0;
    EXPOSE    = 1'b0;
    CONVERT   = 1'b0;
    rd        = '0;
    unique case (state)
      ST_IDLE:
        if (start) state_nxt = ST_ERASE;
      ST_ERASE: begin
        ERASE = 1'b1;
        if (tmr == E_LAST) state_nxt = ST_EXPOSE;
      end
      ST_EXPOSE: begin
        EXPOSE = 1'b1;
        if (tmr == X_LAST) state_nxt = ST_CONVERT;
      end
      ST_CONVERT: begin
        CONVERT = 1'b1;
        if (wrap) state_nxt = ST_RD_SETUP;
      end
      ST_RD_SETUP: begin
        rd = 4'b0001 << k;
        if (tmr == S_LAST) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        rd = 4'b0001 << k;
        if (pix_valid && pix_ready)
          state_nxt = (k == 2'd3) ? ST_DONE : ST_RD_SETUP;
      end
      ST_DONE:
        state_nxt = ST_IDLE;
      default:
        state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      tmr       <= '0;
      k         <= '0;
      pix_data  <= '0;
      pix_idx   <= '0;
      pix_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      tmr   <= (state_nxt != state) ? 8'd0 : tmr + 8'd1;
      // sample at the end of the setup window
      if (state == ST_RD_SETUP && state_nxt == ST_RD_WAIT) begin
        pix_data  <= gray2bin(data_in);
        pix_idx   <= k;
        pix_valid <= 1'b1;
      end
      if (state == ST_RD_WAIT && pix_valid && pix_ready) begin
        pix_valid <= 1'b0;
        k         <= k + 2'd1;
      end
    end
  end

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);
  assign cnt_oe     = CONVERT;
  assign READ1      = rd[0];
  assign READ2      = rd[1];
  assign READ3      = rd[2];
  assign READ4      = rd[3];

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// Directed + randomized frame checks for pixel_array_ctrl
// against a behavioural pixel/timing model.
module tb_pixel_array_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       pix_ready = 1'b1;
  logic       busy, frame_done;
  logic       ERASE, EXPOSE, CONVERT;
  logic       READ1, READ2, READ3, READ4;
  logic [7:0] cnt_data, data_in, pix_data;
  logic       cnt_oe, pix_valid;
  logic [1:0] pix_idx;

  logic [7:0] pv [4];
  int checks = 0;
  int errors = 0;
  int fdone_cnt = 0;

  always #5 clk = ~clk;

  pixel_array_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .ERASE     (ERASE),
    .EXPOSE    (EXPOSE),
    .CONVERT   (CONVERT),
    .READ1     (READ1),
    .READ2     (READ2),
    .READ3     (READ3),
    .READ4     (READ4),
    .cnt_data  (cnt_data),
    .cnt_oe    (cnt_oe),
    .data_in   (data_in),
    .pix_data  (pix_data),
    .pix_idx   (pix_idx),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready)
  );

  function automatic logic [7:0] gray(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  wire [3:0] reads = {READ4, READ3, READ2, READ1};

  // resolved DATA bus: counter while converting, else the selected pixel
  assign data_in = cnt_oe ? cnt_data :
                   READ1  ? gray(pv[0]) :
                   READ2  ? gray(pv[1]) :
                   READ3  ? gray(pv[2]) :
                   READ4  ? gray(pv[3]) : 8'hA5;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (frame_done) fdone_cnt++;
    checks++;
    assert (!(ERASE && EXPOSE)
            && !(cnt_oe && (reads != 4'b0))
            && ($countones(reads) <= 1)
            && ((reads == 4'b0) ||
                (busy && !ERASE && !EXPOSE && !CONVERT && !frame_done)))
    else begin
      errors++;
      $error("FAIL invariant observed=%0h expected=0",
             {ERASE, EXPOSE, cnt_oe, reads});
    end
  end

  function automatic logic [31:0] all_out();
    return {busy, frame_done, ERASE, EXPOSE, CONVERT, reads,
            cnt_oe, pix_valid, cnt_data, pix_data, pix_idx};
  endfunction

  task automatic run_frame(input int bp_pix, input int bp_cyc,
                           input bit noise);
    int n;
    int bad;
    logic [7:0] last;
    logic [7:0] held;
    int fd0;
    fd0 = fdone_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("busy_rise", busy, 1);
    check("erase_first", ERASE, 1);
    n = 0;
    while (ERASE && n < 50) begin n++; @(negedge clk); end
    check("erase_len", n, 5);
    n = 0;
    while (EXPOSE && n < 600) begin
      start = (noise && n == 100);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("expose_len", n, 255);
    n = 0; bad = 0; last = '0;
    while (CONVERT && n < 600) begin
      if (cnt_data !== gray(8'(n))) bad++;
      if (cnt_oe !== 1'b1) bad++;
      last = cnt_data;
      n++;
      @(negedge clk);
    end
    check("conv_len", n, 256);
    check("conv_seq", bad, 0);
    check("conv_last", last, 8'h80);
    check("oe_drop", cnt_oe, 0);
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!pix_valid && n < 20) begin n++; @(negedge clk); end
      check("setup_len", n, 2);
      check("pix_data", pix_data, pv[k]);
      check("pix_idx", pix_idx, k);
      check("read_sel", reads, 32'(4'b0001 << k));
      if (k == bp_pix) begin
        pix_ready = 1'b0;
        held = pix_data;
        bad = 0;
        repeat (bp_cyc) begin
          if (noise) start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          if (!pix_valid || pix_data !== held ||
              reads !== (4'b0001 << k)) bad++;
        end
        check("bp_hold", bad, 0);
        pix_ready = 1'b1;
      end
      @(negedge clk);
      check("valid_clr", pix_valid, 0);
    end
    check("done_pulse", frame_done, 1);
    check("done_reads", reads, 0);
    @(negedge clk);
    check("done_one", frame_done, 0);
    check("idle_busy", busy, 0);
    repeat (10) @(negedge clk);
    check("no_requeue", busy, 0);
    check("done_count", fdone_cnt - fd0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int fd0;
    pv[0] = 8'h33; pv[1] = 8'h66; pv[2] = 8'h99; pv[3] = 8'hCC;
    repeat (3) @(negedge clk);
    check("reset_outs", all_out(), 0);
    reset = 1'b1;
    @(negedge clk);
    check("reset_idle", busy, 0);

    // abort a frame 40 cycles into the conversion
    fd0 = fdone_cnt;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    n = 0;
    while (!CONVERT && n < 400) begin n++; @(negedge clk); end
    check("reach_conv", CONVERT, 1);
    repeat (40) @(negedge clk);
    check("conv_cyc40", cnt_data, gray(8'd40));
    #2 reset = 1'b0;
    #1 check("async_rst", all_out(), 0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_idle", busy, 0);
    check("rst_nodone", fdone_cnt - fd0, 0);

    // fixed pixel values, backpressure on pixel 1
    run_frame(1, 10, 1'b0);

    // start pulses during EXPOSE and READ_WAIT are ignored
    run_frame(3, 4, 1'b1);

    repeat (3) begin
      for (int i = 0; i < 4; i++) pv[i] = 8'($urandom);
      run_frame(int'($urandom_range(0, 3)),
                int'($urandom_range(0, 6)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
Frame sequencer for the 4-pixel PIXEL_ARRAY. Per frame it drives erase, exposure and a ramp-ADC conversion, and generates the 8-bit counter value that the pixels latch. It then reads the four pixels one at a time over the shared DATA bus and hands each sample downstream with a valid/ready handshake. It sits between the system/readout logic and the analog array, and is the only driver of ERASE, EXPOSE, READ1..READ4 and the counter side of DATA.

Parameters:
C_ERASE, 5, cycles ERASE is held high
C_EXPOSE, 255, cycles EXPOSE is held high (8-bit field, legal range 1..255)
C_READ_SETUP, 2, cycles READn is high before DATA is sampled (legal range 1..7)
CNT_W, 8, width of the conversion counter and pixel samples

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  request one frame; sampled only in IDLE
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse when the last pixel has been accepted
ERASE  out  1  pixel erase
EXPOSE  out  1  pixel exposure enable
CONVERT  out  1  high during ramp/counter conversion; gates the analog ramp
READ1..READ4  out  1 each  pixel read selects, one-hot or all-zero
cnt_data  out  CNT_W  conversion counter, Gray coded
cnt_oe  out  1  tristate enable; bus driver places cnt_data on DATA
data_in  in  CNT_W  resolved DATA bus value
pix_data  out  CNT_W  sampled pixel value (binary, Gray-decoded)
pix_idx  out  2  index of the pixel in pix_data (0..3)
pix_valid  out  1  pix_data/pix_idx are valid
pix_ready  in  1  downstream accepts the sample

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; every output 0; counters 0.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> READ_SETUP -> READ_WAIT -> (next pixel READ_SETUP | DONE) -> IDLE.
- IDLE: on start=1, go to ERASE on the next edge. busy rises the same edge.
- ERASE: ERASE=1 for exactly C_ERASE cycles, then EXPOSE.
- EXPOSE: EXPOSE=1 for exactly C_EXPOSE cycles, then CONVERT. ERASE and EXPOSE are never high together.
- CONVERT: CONVERT=1 and cnt_oe=1.
  - A binary counter runs 0..2^CNT_W-1, one step per cycle; cnt_data = bin ^ (bin>>1).
  - On reaching all-ones, go to READ_SETUP. Duration is exactly 2^CNT_W cycles.
  - cnt_oe drops on the same edge that CONVERT drops.
- READ_SETUP (pixel k, k=0..3): READ(k+1)=1, all others 0, cnt_oe=0.
  - After C_READ_SETUP cycles, capture data_in, Gray-decode it into pix_data, set pix_idx=k and pix_valid=1, then go to READ_WAIT.
- READ_WAIT: READ(k+1) stays high and pix_data is held stable.
  - A transfer happens on a cycle with pix_valid & pix_ready; pix_valid clears on the next edge.
  - After the transfer: if k<3, go to READ_SETUP for k+1 (a fresh setup period, no READ overlap); if k=3, go to DONE.
  - pix_ready may be held high; the minimum per-pixel time is C_READ_SETUP+1 cycles.
- DONE: one cycle; frame_done=1, READs all 0, then IDLE.
- start is ignored while busy; no queuing.
- Asynchronous reset in any state immediately drops all pixel controls and cnt_oe, and abandons the frame with no frame_done.
- Bus ownership: cnt_oe and any READn are never high in the same cycle.

Decomposition:
- Package pixel_ctrl_pkg:
  - state enum (IDLE, ERASE, EXPOSE, CONVERT, READ_SETUP, READ_WAIT, DONE)
  - CNT_W default
  - bin2gray and gray2bin functions
- One sub-module, pixel_gray_counter: clk, reset, en, clr, gray out, wrap pulse. Used for the conversion count.
- Phase timers stay inline in the controller.

Test Plan:
1. Reset mid-CONVERT (drive reset=0 at conversion cycle 40): all outputs 0 asynchronously; IDLE after release; no frame_done.
2. Defaults, pix_ready tied 1, start pulse:
   - ERASE high exactly 5 cycles.
   - EXPOSE exactly 255 cycles.
   - CONVERT exactly 256 cycles; cnt_data sequence 00,01,03,02,... ending at 0x80.
   - Four pix_valid pulses with pix_idx 0,1,2,3.
   - frame_done exactly 1 cycle, then busy=0.
3. Pixel model returns Gray(0x33), Gray(0x66), Gray(0x99), Gray(0xCC) on READ1..4 -> pix_data 0x33, 0x66, 0x99, 0xCC in order.
4. Backpressure: pix_ready=0 for 10 cycles on pixel 1 -> pix_valid stays high, pix_data stable, READ2 stays high, READ3 stays low until the transfer.
5. start pulsed during EXPOSE and during READ_WAIT -> ignored; exactly one frame_done; a new frame starts only on a start seen in IDLE.
6. Assertion run over random frames: never ERASE&EXPOSE, never cnt_oe&READn, never two READn high; READn one-hot only in READ_SETUP and READ_WAIT.
